// File: rtl/vga_pkg.sv
// Shared raster timing defaults, swap-control states and the sync window helper.
// Combinational helpers only; no latency and no backpressure.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int CNT_BITS     = 10;

    typedef enum logic {
        SW_IDLE,
        SW_PENDING
    } swap_state_t;

    // True while cnt lies in [start, start+len); the end is computed one bit wider.
    function automatic logic sync_window(input logic [CNT_BITS-1:0] cnt,
                                         input logic [CNT_BITS-1:0] start,
                                         input logic [CNT_BITS-1:0] len);
        logic [CNT_BITS:0] stop;
        stop = {1'b0, start} + {1'b0, len};
        return (cnt >= start) && ({1'b0, cnt} < stop);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register of DEPTH stages; DEPTH=0 is a pass-through wire.
// Latency DEPTH cycles, no backpressure.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vgaclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = vgaclk ^ reset_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge vgaclk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_engine.sv
// VGA raster counters, framebuffer read address and frame-aligned bank swap.
// Address/rden 1 cycle after the counters, syncs/blank 1+RD_LAT; free-running, no backpressure.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   SCALE_LOG2 = 2,
    parameter int   XBITS      = 7,
    parameter int   YBITS      = 7,
    parameter int   RD_LAT     = 1
) (
    input  logic                   vgaclk,
    input  logic                   reset_n,
    input  logic                   swap_req,
    output logic                   rden,
    output logic [YBITS+XBITS:0]   rdaddr,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   sync_b,
    output logic                   blank_n,
    output logic                   frame_start,
    output logic                   swap_ack
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_scan_engine: H_TOTAL and V_TOTAL must fit 10-bit counters");
        end
        if (RD_LAT < 0) begin : g_bad_lat
            $error("vga_scan_engine: RD_LAT must be non-negative");
        end
    endgenerate

    localparam logic [CNT_BITS-1:0] H_ACT  = CNT_BITS'(H_ACTIVE);
    localparam logic [CNT_BITS-1:0] H_LAST = CNT_BITS'(H_TOTAL - 1);
    localparam logic [CNT_BITS-1:0] H_SS   = CNT_BITS'(H_ACTIVE + H_FP);
    localparam logic [CNT_BITS-1:0] H_SL   = CNT_BITS'(H_SYNC);
    localparam logic [CNT_BITS-1:0] V_ACT  = CNT_BITS'(V_ACTIVE);
    localparam logic [CNT_BITS-1:0] V_LAST = CNT_BITS'(V_TOTAL - 1);
    localparam logic [CNT_BITS-1:0] V_SS   = CNT_BITS'(V_ACTIVE + V_FP);
    localparam logic [CNT_BITS-1:0] V_SL   = CNT_BITS'(V_SYNC);

    logic [CNT_BITS-1:0] hcnt, vcnt;
    logic                visible, boundary, toggle, bank;
    logic                hs_a, vs_a, sb_a;
    logic [XBITS-1:0]    xaddr;
    logic [YBITS-1:0]    yaddr;
    swap_state_t         state, state_nxt;

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign visible  = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign boundary = (hcnt == '0) && (vcnt == V_ACT);
    // Excess coordinate bits are dropped so oversized rasters wrap in the buffer.
    assign xaddr    = XBITS'(hcnt >> SCALE_LOG2);
    assign yaddr    = YBITS'(vcnt >> SCALE_LOG2);

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) state <= SW_IDLE;
        else          state <= state_nxt;
    end

    // A request landing on the blanking-entry cycle toggles immediately.
    always_comb begin
        state_nxt = state;
        toggle    = 1'b0;
        case (state)
            SW_IDLE: begin
                if (boundary && swap_req) toggle = 1'b1;
                else if (swap_req)        state_nxt = SW_PENDING;
            end
            SW_PENDING: begin
                if (boundary) begin
                    toggle    = 1'b1;
                    state_nxt = SW_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            rden        <= 1'b0;
            rdaddr      <= '0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            bank        <= 1'b0;
            hs_a        <= ~HSYNC_POL;
            vs_a        <= ~VSYNC_POL;
        end else begin
            rden        <= visible;
            rdaddr      <= visible ? {bank, yaddr, xaddr} : {bank, {(YBITS+XBITS){1'b0}}};
            frame_start <= (hcnt == '0) && (vcnt == '0);
            swap_ack    <= toggle;
            bank        <= bank ^ toggle;
            hs_a        <= sync_window(hcnt, H_SS, H_SL) ? HSYNC_POL : ~HSYNC_POL;
            vs_a        <= sync_window(vcnt, V_SS, V_SL) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign sb_a = ~((hs_a == HSYNC_POL) || (vs_a == VSYNC_POL));

    // Syncs and blank ride alongside the RAM read so they line up with q.
    vga_delay_line #(
        .WIDTH     (4),
        .DEPTH     (RD_LAT),
        .RESET_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b1, 1'b0})
    ) u_stage_b (
        .vgaclk  (vgaclk),
        .reset_n (reset_n),
        .d       ({hs_a, vs_a, sb_a, rden}),
        .q       ({hsync, vsync, sync_b, blank_n})
    );

endmodule

// File: tb/tb_vga_scan_engine.sv
// Three engines (default timing, small raster RD_LAT=1, small raster RD_LAT=3) against a raster model.
module tb_vga_scan_engine;

    localparam int S_HA = 40, S_HFP = 4, S_HS = 6, S_HBP = 6;
    localparam int S_VA = 20, S_VFP = 2, S_VS = 2, S_VBP = 3;

    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, scale, xb, yb, lat;
    } cfg_t;

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        if (i == 0)      c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 7, 7, 1};
        else if (i == 1) c = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 0, 1, 1, 4, 3, 1};
        else             c = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1, 0, 0, 6, 5, 3};
        return c;
    endfunction

    logic vgaclk   = 1'b0;
    logic reset_n  = 1'b0;
    logic swap_req = 1'b0;
    always #5 vgaclk = ~vgaclk;

    logic        rden_d, hs_d, vs_d, sb_d, bn_d, fs_d, ack_d;
    logic [14:0] addr_d;
    logic        rden_s, hs_s, vs_s, sb_s, bn_s, fs_s, ack_s;
    logic [7:0]  addr_s;
    logic        rden_r, hs_r, vs_r, sb_r, bn_r, fs_r, ack_r;
    logic [11:0] addr_r;

    vga_scan_engine dut_d (
        .vgaclk(vgaclk), .reset_n(reset_n), .swap_req(swap_req),
        .rden(rden_d), .rdaddr(addr_d), .hsync(hs_d), .vsync(vs_d),
        .sync_b(sb_d), .blank_n(bn_d), .frame_start(fs_d), .swap_ack(ack_d)
    );

    vga_scan_engine #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SCALE_LOG2(1), .XBITS(4), .YBITS(3), .RD_LAT(1)
    ) dut_s (
        .vgaclk(vgaclk), .reset_n(reset_n), .swap_req(swap_req),
        .rden(rden_s), .rdaddr(addr_s), .hsync(hs_s), .vsync(vs_s),
        .sync_b(sb_s), .blank_n(bn_s), .frame_start(fs_s), .swap_ack(ack_s)
    );

    vga_scan_engine #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .SCALE_LOG2(0), .XBITS(6), .YBITS(5), .RD_LAT(3)
    ) dut_r (
        .vgaclk(vgaclk), .reset_n(reset_n), .swap_req(swap_req),
        .rden(rden_r), .rdaddr(addr_r), .hsync(hs_r), .vsync(vs_r),
        .sync_b(sb_r), .blank_n(bn_r), .frame_start(fs_r), .swap_ack(ack_r)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;   // clock edges since the last reset release

    int          bank_m [3];
    int          pend_m [3];
    logic [3:0]  hist   [3][8];   // per output cycle: {hsync, vsync, sync_b, rden}
    logic        e_rden [3], e_fs [3], e_ack [3], e_hs [3], e_vs [3], e_sb [3], e_bn [3];
    logic [31:0] e_addr [3];

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, i, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cfg_t c;
        ncyc = 0;
        for (int i = 0; i < 3; i++) begin
            c = get_cfg(i);
            bank_m[i] = 0;
            pend_m[i] = 0;
            e_rden[i] = 1'b0;
            e_addr[i] = '0;
            e_fs[i]   = 1'b0;
            e_ack[i]  = 1'b0;
            e_hs[i]   = (c.hpol == 0);
            e_vs[i]   = (c.vpol == 0);
            e_sb[i]   = 1'b1;
            e_bn[i]   = 1'b0;
        end
    endtask

    // Outputs for the edge that consumes raster position ncyc (output cycle ncyc+1).
    task automatic model_step(input int i, input logic req);
        cfg_t c;
        int   ht, vt, h, v, m;
        logic vis, hwin, vwin, hp, vp;
        c    = get_cfg(i);
        ht   = c.ha + c.hfp + c.hs + c.hbp;
        vt   = c.va + c.vfp + c.vs + c.vbp;
        h    = ncyc % ht;
        v    = (ncyc / ht) % vt;
        hp   = (c.hpol != 0);
        vp   = (c.vpol != 0);
        vis  = (h < c.ha) && (v < c.va);
        hwin = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
        vwin = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
        e_rden[i] = vis;
        e_addr[i] = 32'(bank_m[i] << (c.xb + c.yb));
        if (vis)
            e_addr[i] = e_addr[i] | 32'((((v >> c.scale) % (1 << c.yb)) << c.xb) | ((h >> c.scale) % (1 << c.xb)));
        e_fs[i]  = (h == 0) && (v == 0);
        e_ack[i] = (h == 0) && (v == c.va) && (pend_m[i] != 0 || req);
        hist[i][(ncyc + 1) % 8] = {hwin ? hp : ~hp, vwin ? vp : ~vp, ~(hwin || vwin), vis};
        m = ncyc + 1 - c.lat;
        if (m >= 1) {e_hs[i], e_vs[i], e_sb[i], e_bn[i]} = hist[i][m % 8];
        else        {e_hs[i], e_vs[i], e_sb[i], e_bn[i]} = {~hp, ~vp, 1'b1, 1'b0};
        if (e_ack[i]) begin
            bank_m[i] = bank_m[i] ^ 1;
            pend_m[i] = 0;
        end else if (req) begin
            pend_m[i] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge vgaclk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < 3; i++) model_step(i, swap_req);
                ncyc++;
            end
        end
    end

    task automatic check_inst(input int i, input logic rd, input logic [31:0] ad, input logic hs,
                              input logic vs, input logic sb, input logic bn, input logic fs, input logic ak);
        check("rden", i, 32'(rd), 32'(e_rden[i]));
        check("rdaddr", i, ad, e_addr[i]);
        check("hsync", i, 32'(hs), 32'(e_hs[i]));
        check("vsync", i, 32'(vs), 32'(e_vs[i]));
        check("sync_b", i, 32'(sb), 32'(e_sb[i]));
        check("blank_n", i, 32'(bn), 32'(e_bn[i]));
        check("frame_start", i, 32'(fs), 32'(e_fs[i]));
        check("swap_ack", i, 32'(ak), 32'(e_ack[i]));
    endtask

    initial forever begin
        @(negedge vgaclk);
        check_inst(0, rden_d, 32'(addr_d), hs_d, vs_d, sb_d, bn_d, fs_d, ack_d);
        check_inst(1, rden_s, 32'(addr_s), hs_s, vs_s, sb_s, bn_s, fs_s, ack_s);
        check_inst(2, rden_r, 32'(addr_r), hs_r, vs_r, sb_r, bn_r, fs_r, ack_r);
    end

    logic phase1 = 1'b1;
    int   vs_cnt = 0;
    int   fs_cnt = 0;
    initial forever begin
        @(negedge vgaclk);
        if (phase1 && reset_n && ncyc >= 1513 && ncyc <= 3024) begin
            if (vs_s) vs_cnt++;
            if (fs_s) fs_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", ncyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycle(input int n);
        while (ncyc < n) @(negedge vgaclk);
    endtask

    // swap_req is sampled by the edge that consumes raster position p.
    task automatic pulse_at(input int p);
        wait_cycle(p);
        swap_req = 1'b1;
        wait_cycle(p + 1);
        swap_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge vgaclk);
        #2 reset_n = 1'b1;

        wait_cycle(1);
        check("lit_d_rden_c1", 0, 32'(rden_d), 1);
        check("lit_d_addr_c1", 0, 32'(addr_d), 0);
        check("lit_d_fs_c1", 0, 32'(fs_d), 1);
        check("lit_d_blank_c1", 0, 32'(bn_d), 0);
        check("lit_r_rden_c1", 2, 32'(rden_r), 1);
        wait_cycle(2);
        check("lit_d_blank_c2", 0, 32'(bn_d), 1);
        wait_cycle(3);
        check("lit_r_blank_c3", 2, 32'(bn_r), 0);
        wait_cycle(4);
        check("lit_r_blank_c4", 2, 32'(bn_r), 1);

        pulse_at(563);
        pulse_at(580);

        wait_cycle(641);
        check("lit_d_rden_h640", 0, 32'(rden_d), 0);
        check("lit_d_addr_h640", 0, 32'(addr_d), 0);
        wait_cycle(657);
        check("lit_d_hsync_657", 0, 32'(hs_d), 1);
        wait_cycle(658);
        check("lit_d_hsync_658", 0, 32'(hs_d), 0);
        wait_cycle(753);
        check("lit_d_hsync_753", 0, 32'(hs_d), 0);
        wait_cycle(754);
        check("lit_d_hsync_754", 0, 32'(hs_d), 1);

        wait_cycle(1120);
        check("lit_s_ack_pre", 1, 32'(ack_s), 0);
        wait_cycle(1121);
        check("lit_s_ack_bnd", 1, 32'(ack_s), 1);
        wait_cycle(1513);
        check("lit_s_addr_bank1", 1, 32'(addr_s), 32'h80);
        check("lit_s_fs_f1", 1, 32'(fs_s), 1);
        wait_cycle(2633);
        check("lit_s_noreq_ack", 1, 32'(ack_s), 0);
        wait_cycle(3025);
        check("lit_s_fs_f2", 1, 32'(fs_s), 1);

        pulse_at(4144);
        check("lit_s_same_cycle_ack", 1, 32'(ack_s), 1);
        wait_cycle(5657);
        check("lit_s_late_req_ack", 1, 32'(ack_s), 0);
        pulse_at(5657);
        wait_cycle(7169);
        check("lit_s_deferred_ack", 1, 32'(ack_s), 1);

        wait_cycle(7206);
        check("lit_d_addr_5_9", 0, 32'(addr_d), 32'h0101);

        for (int k = 7300; k < 11000; k++) begin
            wait_cycle(k);
            swap_req = ($urandom_range(0, 149) == 0);
        end
        swap_req = 1'b0;

        wait_cycle(13216);
        swap_req = (bank_m[1] == 0);
        wait_cycle(13217);
        swap_req = 1'b0;
        pulse_at(13908);

        wait_cycle(14198);
        #3 reset_n = 1'b0;
        phase1 = 1'b0;
        #1;
        check("rst_s_rden", 1, 32'(rden_s), 0);
        check("rst_s_addr", 1, 32'(addr_s), 0);
        check("rst_s_hsync", 1, 32'(hs_s), 1);
        check("rst_s_vsync", 1, 32'(vs_s), 0);
        check("rst_s_sync_b", 1, 32'(sb_s), 1);
        check("rst_s_blank", 1, 32'(bn_s), 0);
        check("rst_r_hsync", 2, 32'(hs_r), 0);
        repeat (4) @(negedge vgaclk);
        #2 reset_n = 1'b1;

        wait_cycle(1);
        check("lit2_r_fs_c1", 2, 32'(fs_r), 1);
        check("lit2_r_blank_c1", 2, 32'(bn_r), 0);
        wait_cycle(4);
        check("lit2_r_blank_c4", 2, 32'(bn_r), 1);
        wait_cycle(1121);
        check("lit2_s_no_ack", 1, 32'(ack_s), 0);
        wait_cycle(1513);
        check("lit2_s_addr_bank0", 1, 32'(addr_s), 32'h00);
        wait_cycle(3100);

        check("vsync_cycles_per_frame", 1, 32'(vs_cnt), 32'(2 * (S_HA + S_HFP + S_HS + S_HBP)));
        check("frame_start_per_frame", 1, 32'(fs_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
